// File: rtl/trsq8_pkg.sv
// Shared definitions for the TRSQ8 interrupt controller: register offsets and FSM states.
package trsq8_pkg;

  localparam logic [1:0] IRQ_PEND = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_EDGE = 2'd2;
  localparam logic [1:0] IRQ_VEC  = 2'd3;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_ACTIVE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one request line plus a history flop for rising-edge detection.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latched/masked sources, fixed-priority select,
// and an assert/claim/EOI handshake driving the cpu interrupt line.
module irq_ctrl
  import trsq8_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter logic [7:0] LAST_ADDR = 8'hA3,
  parameter int         N_SRC     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic [7:0]       dout,
  output logic [7:0]       din,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [N_SRC-1:0] src,
  output logic             irq
);

  logic [N_SRC-1:0] sync_lvl;
  logic [N_SRC-1:0] sync_rise;
  logic [N_SRC-1:0] pend_reg;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] mask_reg;
  logic [N_SRC-1:0] edge_reg;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] w1c_bits;
  logic [N_SRC-1:0] claim_bits;
  irq_state_t       state_reg;
  logic             irq_reg;
  logic [2:0]       id_reg;
  logic [2:0]       win_id;
  logic             win_valid;
  logic             in_range;
  logic [1:0]       sel;
  logic             wr_pend, wr_mask, wr_edge, wr_vec, rd_vec;
  logic             claim, eoi;
  logic [7:0]       rd_data;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (src[gi]),
      .level (sync_lvl[gi]),
      .rise  (sync_rise[gi])
    );
  end

  assign in_range = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
  assign sel      = 2'(addr - BASE_ADDR);
  assign wr_pend  = wr_en && in_range && (sel == IRQ_PEND);
  assign wr_mask  = wr_en && in_range && (sel == IRQ_MASK);
  assign wr_edge  = wr_en && in_range && (sel == IRQ_EDGE);
  assign wr_vec   = wr_en && in_range && (sel == IRQ_VEC);
  assign rd_vec   = rd_en && in_range && (sel == IRQ_VEC);

  assign eligible = pend_reg & mask_reg;

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    win_id = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 3'(i);
    end
    win_valid = |eligible;
  end

  assign claim    = rd_vec && (state_reg == IRQ_ASSERT) && win_valid;
  assign eoi      = wr_vec && (state_reg == IRQ_ACTIVE);
  assign w1c_bits = wr_pend ? dout[N_SRC-1:0] : '0;

  // Edge bits are sticky until W1C or claim, with a fresh edge taking precedence;
  // level bits simply track the synchronized input.
  always_comb begin
    claim_bits = '0;
    pend_next  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_bits[i] = claim && (win_id == 3'(i));
      if (edge_reg[i])
        pend_next[i] = (pend_reg[i] & ~w1c_bits[i] & ~claim_bits[i]) | sync_rise[i];
      else
        pend_next[i] = sync_lvl[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg <= '0;
      mask_reg <= '0;
      edge_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      if (wr_mask) mask_reg <= dout[N_SRC-1:0];
      if (wr_edge) edge_reg <= dout[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IRQ_IDLE;
      irq_reg   <= 1'b0;
      id_reg    <= 3'd0;
    end else begin
      case (state_reg)
        IRQ_IDLE: begin
          if (win_valid) begin
            state_reg <= IRQ_ASSERT;
            irq_reg   <= 1'b1;
          end
        end
        IRQ_ASSERT: begin
          if (!win_valid) begin
            state_reg <= IRQ_IDLE;
            irq_reg   <= 1'b0;
          end else if (claim) begin
            id_reg    <= win_id;
            state_reg <= IRQ_ACTIVE;
            irq_reg   <= 1'b0;
          end
        end
        IRQ_ACTIVE: begin
          if (eoi) state_reg <= IRQ_IDLE;
        end
        default: begin
          state_reg <= IRQ_IDLE;
          irq_reg   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_en && in_range) begin
      case (sel)
        IRQ_PEND: rd_data = 8'(pend_reg);
        IRQ_MASK: rd_data = 8'(mask_reg);
        IRQ_EDGE: rd_data = 8'(edge_reg);
        default: begin
          if (state_reg == IRQ_ACTIVE)
            rd_data = {1'b1, 4'b0000, id_reg};
          else if (state_reg == IRQ_ASSERT && win_valid)
            rd_data = {1'b1, 4'b0000, win_id};
        end
      endcase
    end
  end

  assign din = rd_data;
  assign irq = irq_reg;

endmodule
